reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised successor to the CPU's fixed four-register 8-bit file.
- Provides NUM_REGS registers of WIDTH bits with:
  - one write port
  - two gated read ports with optional write-forwarding
  - an increment/decrement counter port with zero flag, for loop counters
  - a shadow bank with save/restore/swap for interrupt context switching
- Sits between the control unit (selects, strobes) and the ALU operand buses.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- NUM_REGS, 4, number of architectural registers (2..16; need not be a power of two).
- SEL_W, 2, select width; must equal ceil(log2(NUM_REGS)), checked at elaboration.
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read ports; 0 = reads show the stored value only.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- reg_w  in  1  write enable.
- reg_w_select  in  SEL_W  write register index.
- reg_w_line  in  WIDTH  write data.
- reg_r_a  in  1  read port A enable.
- reg_r_a_select  in  SEL_W  read port A index.
- reg_r_a_line  out  WIDTH  read port A data.
- reg_r_b  in  1  read port B enable.
- reg_r_b_select  in  SEL_W  read port B index.
- reg_r_b_line  out  WIDTH  read port B data.
- reg_inc  in  1  increment the counter-port register.
- reg_dec  in  1  decrement the counter-port register.
- reg_c_select  in  SEL_W  counter-port register index.
- reg_c_zero  out  1  registered flag: the last effective count op produced 0.
- bank_save  in  1  copy all live registers into the shadow bank.
- bank_restore  in  1  copy the shadow bank into the live registers.
- regs_flat  out  NUM_REGS*WIDTH  debug view of the live registers; reg i occupies bits [i*WIDTH +: WIDTH].

Behaviour:
- Reset (clk edge with reset=1):
  - All live and shadow registers, and reg_c_zero, go to 0.
  - All other inputs are ignored that cycle; reset overrides every operation in flight.
- Read ports are combinational:
  - Enable low -> line = 0.
  - Enable high -> line = live[select].
  - Select >= NUM_REGS -> line = 0.
- Forwarding: with BYPASS=1, if reg_w=1, the read is enabled and the read select equals reg_w_select (in range), the line shows reg_w_line in the same cycle. With BYPASS=0, a write becomes visible on the read ports and regs_flat one cycle after the edge.
- Write: on the edge with reg_w=1 and an in-range select, live[reg_w_select] <= reg_w_line. An out-of-range select has no effect.
- Counter port (in-range reg_c_select only):
  - inc=1, dec=0 -> live[sel] <= live[sel]+1 mod 2^WIDTH.
  - dec=1, inc=0 -> live[sel] <= live[sel]-1 mod 2^WIDTH.
  - Both or neither -> no op; reg_c_zero holds.
  - On an effective op, reg_c_zero <= (new value == 0).
  - Wrap: all-ones +1 -> 0, flag 1; 0 -1 -> all-ones, flag 0.
- Bank ops (evaluated from pre-edge values):
  - save only -> shadow <= live.
  - restore only -> live <= shadow.
  - Both -> swap live and shadow atomically.
- Priority per live register, highest first: reset > write > count op > restore/swap.
  - Write and count op on the same register -> write wins; reg_c_zero holds (the count op is not effective).
  - Restore plus write to register k -> k takes the write data; all others take shadow.
  - Restore plus count op on register k -> k gets pre-edge live[k]±1; all others take shadow.
  - The shadow bank is never affected by write or count ops; save captures pre-edge live values.
- Independent operations on different registers complete in the same cycle.
- Latency:
  - Write, count, save and restore: 1 cycle.
  - Reads: 0 cycles.
  - Single registered stage; no stalls or back-pressure.

Test Plan:
- Reset, then write AA/BB/CC/DD to regs 0..3 on consecutive cycles; read A=0, B=3 -> A=AA, B=DD; regs_flat=DDCCBBAA; reads with enables low -> 00.
- BYPASS=1: write 5A to reg 2 while A reads reg 2 -> A=5A in the same cycle; repeat with BYPASS=0 -> A shows the old value (CC), then 5A next cycle.
- Reg 1=FF, one reg_inc pulse -> reg1=00, zero=1; then reg_dec -> reg1=FF, zero=0; inc+dec together -> reg1 and zero unchanged.
- Same cycle: reg_w to reg 1 = 11 and reg_inc on reg 1 -> reg1=11 and zero unchanged; reg_w to reg 0 and inc reg 1 together -> both take effect.
- Live regs 0..3 = 01..04, bank_save; write 0..3 = F0..F3; bank_restore -> live 01..04; save+restore together -> live/shadow swapped; restore with a write of 77 to reg 2 -> reg2=77, others from shadow.
- Mid-sequence reset during a save+count cycle -> all regs, shadow and zero=0 next cycle; NUM_REGS=3, select 3 -> write ignored, reads 0.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised register file with write, gated reads, counter port and shadow bank
module reg_file_mp #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = 2,
  parameter int BYPASS   = 1
)(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      reg_w,
  input  logic [SEL_W-1:0]          reg_w_select,
  input  logic [WIDTH-1:0]          reg_w_line,
  input  logic                      reg_r_a,
  input  logic [SEL_W-1:0]          reg_r_a_select,
  output logic [WIDTH-1:0]          reg_r_a_line,
  input  logic                      reg_r_b,
  input  logic [SEL_W-1:0]          reg_r_b_select,
  output logic [WIDTH-1:0]          reg_r_b_line,
  input  logic                      reg_inc,
  input  logic                      reg_dec,
  input  logic [SEL_W-1:0]          reg_c_select,
  output logic                      reg_c_zero,
  input  logic                      bank_save,
  input  logic                      bank_restore,
  output logic [NUM_REGS*WIDTH-1:0] regs_flat
);
  localparam logic [SEL_W:0] NR = (SEL_W+1)'(NUM_REGS);
  if (SEL_W != $clog2(NUM_REGS) || WIDTH < 2 || NUM_REGS < 2 || NUM_REGS > 16) begin : g_param_chk
    $error("reg_file_mp: illegal WIDTH/NUM_REGS/SEL_W combination");
  end
  logic [WIDTH-1:0] live      [NUM_REGS];
  logic [WIDTH-1:0] shadow    [NUM_REGS];
  logic [WIDTH-1:0] live_nx   [NUM_REGS];
  logic [WIDTH-1:0] shadow_nx [NUM_REGS];
  logic             w_ok, a_ok, b_ok, c_ok, c_eff, zero_nx;
  logic [WIDTH-1:0] c_cur, c_val;
  function automatic logic in_range(input logic [SEL_W-1:0] s);
    return {1'b0, s} < NR;
  endfunction
  // combinational read ports with optional same-cycle write forwarding
  always_comb begin
    w_ok = reg_w && in_range(reg_w_select);
    a_ok = reg_r_a && in_range(reg_r_a_select);
    b_ok = reg_r_b && in_range(reg_r_b_select);
    reg_r_a_line = !a_ok ? '0 : (BYPASS != 0 && w_ok && reg_w_select == reg_r_a_select) ? reg_w_line : live[reg_r_a_select];
    reg_r_b_line = !b_ok ? '0 : (BYPASS != 0 && w_ok && reg_w_select == reg_r_b_select) ? reg_w_line : live[reg_r_b_select];
  end
  // next-state: write beats count op beats restore/swap, shadow only sees save
  always_comb begin
    c_ok    = (reg_inc ^ reg_dec) && in_range(reg_c_select);
    c_eff   = c_ok && !(w_ok && reg_w_select == reg_c_select);
    c_cur   = live[reg_c_select];
    c_val   = reg_inc ? c_cur + WIDTH'(1) : c_cur - WIDTH'(1);
    zero_nx = c_eff ? (c_val == '0) : reg_c_zero;
    regs_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      live_nx[i]   = (w_ok && reg_w_select == SEL_W'(i)) ? reg_w_line :
                     (c_eff && reg_c_select == SEL_W'(i)) ? c_val :
                     bank_restore ? shadow[i] : live[i];
      shadow_nx[i] = bank_save ? live[i] : shadow[i];
      regs_flat[i*WIDTH +: WIDTH] = live[i];
    end
  end
  // single registered stage for live bank, shadow bank and zero flag
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        live[i]   <= '0;
        shadow[i] <= '0;
      end
      reg_c_zero <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        live[i]   <= live_nx[i];
        shadow[i] <= shadow_nx[i];
      end
      reg_c_zero <= zero_nx;
    end
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: scoreboard bench driving a forwarding 4-reg file and a non-forwarding 3-reg file in parallel
module tb_reg_file_mp;
  logic clk = 1'b0;
  logic reset, reg_w, reg_r_a, reg_r_b, reg_inc, reg_dec, bank_save, bank_restore;
  logic [1:0] reg_w_select, reg_r_a_select, reg_r_b_select, reg_c_select;
  logic [7:0] reg_w_line;
  logic [7:0] a1, b1, a0, b0;
  logic z1, z0;
  logic [31:0] flat1;
  logic [23:0] flat0;
  typedef struct {
    int          sig;
    logic [31:0] exp;
    string       name;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int passed = 0;
  always #5 clk = ~clk;
  reg_file_mp #(.WIDTH(8), .NUM_REGS(4), .SEL_W(2), .BYPASS(1)) dut1 (
    .clk(clk), .reset(reset), .reg_w(reg_w), .reg_w_select(reg_w_select), .reg_w_line(reg_w_line),
    .reg_r_a(reg_r_a), .reg_r_a_select(reg_r_a_select), .reg_r_a_line(a1),
    .reg_r_b(reg_r_b), .reg_r_b_select(reg_r_b_select), .reg_r_b_line(b1),
    .reg_inc(reg_inc), .reg_dec(reg_dec), .reg_c_select(reg_c_select), .reg_c_zero(z1),
    .bank_save(bank_save), .bank_restore(bank_restore), .regs_flat(flat1));
  reg_file_mp #(.WIDTH(8), .NUM_REGS(3), .SEL_W(2), .BYPASS(0)) dut0 (
    .clk(clk), .reset(reset), .reg_w(reg_w), .reg_w_select(reg_w_select), .reg_w_line(reg_w_line),
    .reg_r_a(reg_r_a), .reg_r_a_select(reg_r_a_select), .reg_r_a_line(a0),
    .reg_r_b(reg_r_b), .reg_r_b_select(reg_r_b_select), .reg_r_b_line(b0),
    .reg_inc(reg_inc), .reg_dec(reg_dec), .reg_c_select(reg_c_select), .reg_c_zero(z0),
    .bank_save(bank_save), .bank_restore(bank_restore), .regs_flat(flat0));
  // monitor: outputs settle by the falling edge, so pending expectations are checked there
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.sig)
        0: act = {24'h0, a1};
        1: act = {24'h0, b1};
        2: act = flat1;
        3: act = {31'h0, z1};
        4: act = {24'h0, a0};
        5: act = {24'h0, b0};
        6: act = {8'h0, flat0};
        default: act = {31'h0, z0};
      endcase
      checks++;
      if (act === e.exp) passed++;
      else $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
    end
  end
  task automatic chk(input int sig, input logic [31:0] v, input string n);
    exp_t e;
    e.sig = sig; e.exp = v; e.name = n;
    q.push_back(e);
  endtask
  task automatic step();
    @(posedge clk); #1;
    reset = 0; reg_w = 0; reg_r_a = 0; reg_r_b = 0; reg_inc = 0; reg_dec = 0;
    bank_save = 0; bank_restore = 0;
    reg_w_select = 0; reg_r_a_select = 0; reg_r_b_select = 0; reg_c_select = 0; reg_w_line = 0;
  endtask
  task automatic wr(input logic [1:0] s, input logic [7:0] v);
    reg_w = 1; reg_w_select = s; reg_w_line = v;
  endtask
  initial begin
    logic [7:0] wv [4];
    step(); reset = 1;
    step();
    chk(2, 32'h0, "reset_flat1"); chk(6, 32'h0, "reset_flat0");
    chk(3, 32'h0, "reset_zero1"); chk(7, 32'h0, "reset_zero0");
    wv[0] = 8'hAA; wv[1] = 8'hBB; wv[2] = 8'hCC; wv[3] = 8'hDD;
    for (int i = 0; i < 4; i++) begin
      wr(2'(i), wv[i]); step();
    end
    reg_r_a = 1; reg_r_a_select = 0; reg_r_b = 1; reg_r_b_select = 3;
    chk(0, 32'hAA, "read_a_r0"); chk(1, 32'hDD, "read_b_r3");
    chk(2, 32'hDDCCBBAA, "flat1_after_writes"); chk(6, 32'hCCBBAA, "flat0_after_writes");
    chk(4, 32'hAA, "n3_read_a_r0"); chk(5, 32'h00, "n3_read_b_sel3_out_of_range");
    step(); reg_r_a_select = 0; reg_r_b_select = 3;
    chk(0, 32'h00, "read_a_disabled"); chk(1, 32'h00, "read_b_disabled");
    step(); wr(2, 8'h5A); reg_r_a = 1; reg_r_a_select = 2; reg_r_b = 1; reg_r_b_select = 2;
    chk(0, 32'h5A, "bypass_a_fwd"); chk(1, 32'h5A, "bypass_b_fwd");
    chk(4, 32'hCC, "nobypass_a_old"); chk(2, 32'hDDCCBBAA, "flat1_before_edge");
    step(); reg_r_a = 1; reg_r_a_select = 2;
    chk(0, 32'h5A, "bypass_a_after"); chk(4, 32'h5A, "nobypass_a_after");
    wr(1, 8'hFF);
    step(); reg_inc = 1; reg_c_select = 1;
    step();
    chk(2, 32'hDD5A00AA, "inc_wrap_flat1"); chk(3, 32'h1, "inc_wrap_zero1");
    chk(6, 32'h5A00AA, "inc_wrap_flat0"); chk(7, 32'h1, "inc_wrap_zero0");
    reg_dec = 1; reg_c_select = 1;
    step();
    chk(2, 32'hDD5AFFAA, "dec_wrap_flat1"); chk(3, 32'h0, "dec_wrap_zero1");
    reg_inc = 1; reg_dec = 1; reg_c_select = 1;
    step();
    chk(2, 32'hDD5AFFAA, "incdec_noop_flat1"); chk(3, 32'h0, "incdec_noop_zero1");
    reg_inc = 1; reg_c_select = 1;
    step();
    chk(3, 32'h1, "inc_again_zero1");
    wr(1, 8'h11); reg_inc = 1; reg_c_select = 1;
    step();
    chk(2, 32'hDD5A11AA, "write_beats_inc_flat1"); chk(3, 32'h1, "write_beats_inc_zero_hold");
    wr(0, 8'h22); reg_inc = 1; reg_c_select = 1;
    step();
    chk(2, 32'hDD5A1222, "write_and_inc_flat1"); chk(3, 32'h0, "write_and_inc_zero1");
    chk(6, 32'h5A1222, "write_and_inc_flat0");
    for (int i = 0; i < 4; i++) begin
      wr(2'(i), 8'(i + 1)); step();
    end
    chk(2, 32'h04030201, "bank_setup_flat1");
    bank_save = 1; wr(0, 8'hF0);
    for (int i = 1; i < 4; i++) begin
      step(); wr(2'(i), 8'hF0 + 8'(i));
    end
    step();
    chk(2, 32'hF3F2F1F0, "overwrite_flat1");
    bank_restore = 1;
    step();
    chk(2, 32'h04030201, "restore_flat1"); chk(6, 32'h030201, "restore_flat0");
    wr(0, 8'hA0);
    step(); wr(3, 8'hA3);
    step(); bank_save = 1; bank_restore = 1;
    step();
    chk(2, 32'h04030201, "swap_live_flat1"); chk(6, 32'h030201, "swap_live_flat0");
    bank_restore = 1; wr(2, 8'h77);
    step();
    chk(2, 32'hA37702A0, "restore_write_flat1"); chk(6, 32'h7702A0, "restore_write_flat0");
    bank_restore = 1; reg_inc = 1; reg_c_select = 1;
    step();
    chk(2, 32'hA30303A0, "restore_inc_flat1"); chk(6, 32'h0303A0, "restore_inc_flat0");
    chk(3, 32'h0, "restore_inc_zero1");
    wr(1, 8'h01);
    step(); reg_dec = 1; reg_c_select = 1;
    step();
    chk(3, 32'h1, "pre_reset_zero1");
    reset = 1; bank_save = 1; reg_inc = 1; reg_c_select = 0; wr(2, 8'h99);
    step();
    chk(2, 32'h0, "midreset_flat1"); chk(6, 32'h0, "midreset_flat0");
    chk(3, 32'h0, "midreset_zero1"); chk(7, 32'h0, "midreset_zero0");
    wr(0, 8'h55);
    step();
    chk(2, 32'h00000055, "post_reset_write_flat1");
    bank_restore = 1;
    step();
    chk(2, 32'h0, "shadow_cleared_flat1"); chk(6, 32'h0, "shadow_cleared_flat0");
    wr(3, 8'h3C); reg_r_a = 1; reg_r_a_select = 3;
    chk(4, 32'h00, "n3_sel3_read_zero");
    step();
    chk(6, 32'h0, "n3_sel3_write_ignored"); chk(2, 32'h3C000000, "n4_sel3_write");
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
